// File: rtl/cpu_bus_controller.sv
//==============================================================================
// cpu_bus_controller : CPU bus decode, 2 KiB work RAM, external port with
// wait states and open-bus latch. Optional macro: BUS_TIMEOUT_EN.
// Revision: 1.0
//==============================================================================
`default_nettype none

module cpu_bus_controller #(
   parameter int          RAM_ADDRESS_BITS = 11,
   parameter logic [15:0] RAM_REGION_END   = 16'h1FFF,
   parameter int          TIMEOUT_CYCLES   = 32
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        cycle_start_i,
   input  logic [15:0] address_i,
   input  logic [7:0]  data_i,
   input  logic        bus_read_i,
   input  logic        bus_write_i,
   output logic [7:0]  data_o,
   output logic        data_valid_o,
   output logic        ext_request_o,
   output logic [15:0] ext_address_o,
   output logic [7:0]  ext_data_o,
   output logic        ext_write_o,
   input  logic [7:0]  ext_data_i,
   input  logic        ext_ack_i,
   output logic        timeout_o
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RAM_READ = 2'd1,
      EXT_WAIT = 2'd2,
      DONE     = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  data_q, data_d;
   logic [7:0]  latch_q, latch_d;
   logic        valid_q, valid_d;
   logic        req_q, req_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        wr_q, wr_d;
   logic [7:0]  ram_rd_q, ram_rd_d;

   logic [7:0]  ram [2**RAM_ADDRESS_BITS];
   logic [RAM_ADDRESS_BITS-1:0] ram_idx;
   logic        is_ram;
   logic        ram_we;

`ifdef BUS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;
   assign timeout_o = timeout_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
   assign timeout_o = 1'b0;
`endif

   assign ram_idx = address_i[RAM_ADDRESS_BITS-1:0];
   assign is_ram  = (address_i <= RAM_REGION_END);
   assign ram_we  = cycle_start_i & bus_write_i & is_ram & ~reset_i;

   always_comb begin
      ram_rd_d = ram[ram_idx];
   end

   always_ff @(posedge clock_i) begin
      if (ram_we)
         ram[ram_idx] <= data_i;
      ram_rd_q <= ram_rd_d;
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      latch_d = latch_q;
      valid_d = valid_q;
      req_d   = req_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wr_d    = wr_q;
`ifdef BUS_TIMEOUT_EN
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
`endif
      if (cycle_start_i) begin
         addr_d  = address_i;
         wdata_d = data_i;
         wr_d    = bus_write_i;
         req_d   = 1'b0;
         valid_d = 1'b0;
`ifdef BUS_TIMEOUT_EN
         cnt_d   = '0;
`endif
         // A start while an access is still in flight abandons it.
         if (state_q == RAM_READ || state_q == EXT_WAIT)
            data_d = latch_q;
         if (!bus_write_i && !bus_read_i) begin
            state_d = DONE;
            valid_d = 1'b1;
            data_d  = latch_q;
         end else if (!is_ram) begin
            state_d = EXT_WAIT;
            req_d   = 1'b1;
         end else if (bus_write_i) begin
            state_d = DONE;
            valid_d = 1'b1;
            latch_d = data_i;
         end else begin
            state_d = RAM_READ;
         end
      end else begin
         case (state_q)
            RAM_READ: begin
               state_d = DONE;
               data_d  = ram_rd_q;
               latch_d = ram_rd_q;
               valid_d = 1'b1;
            end
            EXT_WAIT: begin
               if (ext_ack_i) begin
                  state_d = DONE;
                  req_d   = 1'b0;
                  valid_d = 1'b1;
                  if (wr_q) begin
                     latch_d = wdata_q;
                  end else begin
                     data_d  = ext_data_i;
                     latch_d = ext_data_i;
                  end
               end
`ifdef BUS_TIMEOUT_EN
               else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  state_d   = DONE;
                  req_d     = 1'b0;
                  valid_d   = 1'b1;
                  timeout_d = 1'b1;
                  data_d    = latch_q;
               end else if (cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
                  cnt_d = cnt_q + 1'b1;
               end
`endif
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         data_q  <= '0;
         latch_q <= '0;
         valid_q <= 1'b0;
         req_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
`ifdef BUS_TIMEOUT_EN
         cnt_q     <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         latch_q <= latch_d;
         valid_q <= valid_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
`ifdef BUS_TIMEOUT_EN
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   assign data_o        = data_q;
   assign data_valid_o  = valid_q;
   assign ext_request_o = req_q;
   assign ext_address_o = addr_q;
   assign ext_data_o    = wdata_q;
   assign ext_write_o   = wr_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_bus_controller.sv
//==============================================================================
// tb_cpu_bus_controller : directed scoreboard bench for cpu_bus_controller.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_cpu_bus_controller;

   logic        clock_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        cycle_start_i = 1'b0;
   logic [15:0] address_i = '0;
   logic [7:0]  data_i = '0;
   logic        bus_read_i = 1'b0;
   logic        bus_write_i = 1'b0;
   logic [7:0]  data_o;
   logic        data_valid_o;
   logic        ext_request_o;
   logic [15:0] ext_address_o;
   logic [7:0]  ext_data_o;
   logic        ext_write_o;
   logic [7:0]  ext_data_i = '0;
   logic        ext_ack_i = 1'b0;
   logic        timeout_o;

   int passed = 0;
   int total  = 0;
   logic [7:0] sb[$];

   cpu_bus_controller #(
      .RAM_ADDRESS_BITS(11),
      .RAM_REGION_END(16'h1FFF),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clock_i(clock_i),
      .reset_i(reset_i),
      .cycle_start_i(cycle_start_i),
      .address_i(address_i),
      .data_i(data_i),
      .bus_read_i(bus_read_i),
      .bus_write_i(bus_write_i),
      .data_o(data_o),
      .data_valid_o(data_valid_o),
      .ext_request_o(ext_request_o),
      .ext_address_o(ext_address_o),
      .ext_data_o(ext_data_o),
      .ext_write_o(ext_write_o),
      .ext_data_i(ext_data_i),
      .ext_ack_i(ext_ack_i),
      .timeout_o(timeout_o)
   );

   always #5 clock_i = ~clock_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Drives a start pulse for one clock; returns mid-clock N+1.
   task automatic start(input logic [15:0] a, input logic [7:0] d, input logic rd, input logic wr);
      address_i     = a;
      data_i        = d;
      bus_read_i    = rd;
      bus_write_i   = wr;
      cycle_start_i = 1'b1;
      @(negedge clock_i);
      cycle_start_i = 1'b0;
      bus_read_i    = 1'b0;
      bus_write_i   = 1'b0;
      address_i     = 16'(($urandom));
      data_i        = 8'($urandom);
   endtask

   task automatic wait_done(input string tag, input int exp_lat);
      int lat = 1;
      logic [7:0] exp;
      while (!data_valid_o && lat < 20) begin
         @(negedge clock_i);
         lat++;
      end
      chk({tag, " latency"}, lat, exp_lat);
      exp = sb.pop_front();
      chk({tag, " data"}, data_o, exp);
   endtask

   task automatic ext_access(input string tag, input logic [15:0] a, input logic [7:0] wd,
                             input logic wr, input int waits, input logic [7:0] ack_data,
                             input logic [7:0] exp_data);
      sb.push_back(exp_data);
      start(a, wd, ~wr, wr);
      for (int i = 0; i < waits; i++) begin
         chk({tag, " req"}, ext_request_o, 1'b1);
         chk({tag, " addr"}, ext_address_o, a);
         chk({tag, " wr"}, ext_write_o, wr);
         chk({tag, " valid low"}, data_valid_o, 1'b0);
         chk({tag, " no timeout"}, timeout_o, 1'b0);
         if (wr) chk({tag, " wdata"}, ext_data_o, wd);
         @(negedge clock_i);
      end
      chk({tag, " req at ack"}, ext_request_o, 1'b1);
      chk({tag, " addr at ack"}, ext_address_o, a);
      ext_ack_i  = 1'b1;
      ext_data_i = ack_data;
      @(negedge clock_i);
      ext_ack_i  = 1'b0;
      ext_data_i = 8'($urandom);
      chk({tag, " req dropped"}, ext_request_o, 1'b0);
      chk({tag, " valid"}, data_valid_o, 1'b1);
      chk({tag, " data"}, data_o, sb.pop_front());
   endtask

   initial begin
      repeat (3) @(negedge clock_i);
      reset_i = 1'b0;
      chk("reset data", data_o, 8'h00);
      chk("reset valid", data_valid_o, 1'b0);
      chk("reset req", ext_request_o, 1'b0);
      chk("reset addr", ext_address_o, 16'h0000);
      chk("reset wdata", ext_data_o, 8'h00);
      chk("reset wr", ext_write_o, 1'b0);
      chk("reset timeout", timeout_o, 1'b0);

      // RAM mirror
      sb.push_back(8'h00); start(16'h0012, 8'h5A, 1'b0, 1'b1); wait_done("ram wr 0012", 1);
      sb.push_back(8'h5A); start(16'h0812, 8'h00, 1'b1, 1'b0); wait_done("ram rd 0812", 2);
      sb.push_back(8'h5A); start(16'h1812, 8'h00, 1'b1, 1'b0); wait_done("ram rd 1812", 2);

      // Region boundary: 1FFF is RAM (index 7FF), 2000 goes external
      sb.push_back(8'h5A); start(16'h1FFF, 8'hE1, 1'b0, 1'b1); wait_done("ram wr 1fff", 1);
      sb.push_back(8'hE1); start(16'h07FF, 8'h00, 1'b1, 1'b0); wait_done("ram rd 07ff", 2);

      ext_access("ext rd fffc", 16'hFFFC, 8'h00, 1'b0, 3, 8'h34, 8'h34);
      ext_access("ext rd 2000", 16'h2000, 8'h00, 1'b0, 0, 8'hC3, 8'hC3);
      sb.push_back(8'hC3); start(16'h0100, 8'h00, 1'b0, 1'b0); wait_done("open bus c3", 1);

      // External write leaves data_o alone but loads the latch
      ext_access("ext wr 8000", 16'h8000, 8'h9C, 1'b1, 1, 8'h55, 8'hC3);
      sb.push_back(8'h9C); start(16'h0100, 8'h00, 1'b0, 1'b0); wait_done("open bus 9c", 1);

      // Both strobes high behaves as a write
      sb.push_back(8'h9C); start(16'h0030, 8'h66, 1'b1, 1'b1); wait_done("rw as write", 1);
      sb.push_back(8'h66); start(16'h0030, 8'h00, 1'b1, 1'b0); wait_done("rd after rw", 2);

      // Protocol error: RAM read started while external read is waiting
      sb.push_back(8'h66); start(16'h0000, 8'h11, 1'b0, 1'b1); wait_done("ram wr 0000", 1);
      start(16'h4000, 8'h00, 1'b1, 1'b0);
      chk("perr req up", ext_request_o, 1'b1);
      @(negedge clock_i);
      sb.push_back(8'h11);
      start(16'h0000, 8'h00, 1'b1, 1'b0);
      chk("perr req dropped", ext_request_o, 1'b0);
      wait_done("perr ram rd", 2);

`ifdef BUS_TIMEOUT_EN
      sb.push_back(8'h11);
      start(16'hA000, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         chk("to req", ext_request_o, 1'b1);
         chk("to pulse early", timeout_o, 1'b0);
         @(negedge clock_i);
      end
      chk("to req dropped", ext_request_o, 1'b0);
      chk("to pulse", timeout_o, 1'b1);
      chk("to valid", data_valid_o, 1'b1);
      chk("to data", data_o, sb.pop_front());
      @(negedge clock_i);
      chk("to pulse single", timeout_o, 1'b0);
`else
      ext_access("ext long wait", 16'hA000, 8'h00, 1'b0, 8, 8'h42, 8'h42);
`endif

      // Reset mid-access, then a stale ack
      sb.push_back(data_o === 8'hXX ? 8'h00 : data_o);
      sb.pop_back();
      sb.push_back(8'h00);
      start(16'h0020, 8'h77, 1'b0, 1'b1);
      @(negedge clock_i);
      sb.delete();
      start(16'h5000, 8'h00, 1'b1, 1'b0);
      @(negedge clock_i);
      reset_i = 1'b1;
      @(negedge clock_i);
      reset_i    = 1'b0;
      ext_ack_i  = 1'b1;
      ext_data_i = 8'hEE;
      @(negedge clock_i);
      ext_ack_i  = 1'b0;
      chk("rst req", ext_request_o, 1'b0);
      chk("rst valid", data_valid_o, 1'b0);
      chk("rst data", data_o, 8'h00);
      chk("rst timeout", timeout_o, 1'b0);
      @(negedge clock_i);
      chk("rst late ack valid", data_valid_o, 1'b0);
      chk("rst late ack data", data_o, 8'h00);
      sb.push_back(8'h77); start(16'h0020, 8'h00, 1'b1, 1'b0); wait_done("ram kept", 2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
